// File: rtl/rename_rat.sv
// Register alias table with a circular physical-register free list and a one-entry output stage.
// Optional feature macro RENAME_WB_BYPASS_EN forwards a same-cycle writeback into source readiness.
module rename_rat #(
  parameter int unsigned NUM_AREG = 32,
  parameter int unsigned NUM_PREG = 64,
  localparam int unsigned AW = $clog2(NUM_AREG),
  localparam int unsigned PW = $clog2(NUM_PREG)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_sr1,
  input  logic [AW-1:0] in_sr2,
  input  logic [AW-1:0] in_dr,
  input  logic          in_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_sr1_p,
  output logic [PW-1:0] out_sr2_p,
  output logic [PW-1:0] out_dr_p,
  output logic [PW-1:0] out_old_dr_p,
  output logic          out_s1_ready,
  output logic          out_s2_ready,
  input  logic          wb_valid,
  input  logic [PW-1:0] wb_preg,
  input  logic          cm_valid,
  input  logic [PW-1:0] cm_preg,
  output logic [PW:0]   free_count
);

  localparam int unsigned CW        = PW + 1;
  localparam int unsigned FREE_INIT = NUM_PREG - NUM_AREG;

  logic [PW-1:0]       rat  [NUM_AREG];
  logic [PW-1:0]       fifo [NUM_PREG];
  logic [NUM_PREG-1:0] rdy;
  logic [NUM_PREG-1:0] rdy_nxt;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [PW-1:0]       head_nxt;
  logic [PW-1:0]       tail_nxt;

  logic          xfer;
  logic          alloc;
  logic          push;
  logic [PW-1:0] s1_p;
  logic [PW-1:0] s2_p;
  logic          s1_rdy;
  logic          s2_rdy;
  logic [PW-1:0] new_p;
  logic [PW-1:0] old_p;

  // Handshake, source lookup (pre-update RAT), allocation and free-list pointer math
  always_comb begin
    in_ready = (!out_valid || out_ready) && !(in_we && in_dr != '0 && free_count == '0);
    xfer     = in_valid && in_ready;
    alloc    = xfer && in_we && in_dr != '0;
    push     = cm_valid && cm_preg != '0 && free_count != CW'(NUM_PREG);

    s1_p = (in_sr1 == '0) ? '0 : rat[in_sr1];
    s2_p = (in_sr2 == '0) ? '0 : rat[in_sr2];
`ifdef RENAME_WB_BYPASS_EN
    s1_rdy = rdy[s1_p] || (wb_valid && wb_preg == s1_p);
    s2_rdy = rdy[s2_p] || (wb_valid && wb_preg == s2_p);
`else
    s1_rdy = rdy[s1_p];
    s2_rdy = rdy[s2_p];
`endif

    new_p = alloc ? fifo[head] : '0;
    old_p = alloc ? rat[in_dr] : '0;

    head_nxt = (head == PW'(NUM_PREG - 1)) ? '0 : head + PW'(1);
    tail_nxt = (tail == PW'(NUM_PREG - 1)) ? '0 : tail + PW'(1);

    // A fresh allocation clears readiness even if a stray writeback names the same preg
    rdy_nxt = rdy;
    if (wb_valid && wb_preg != '0) rdy_nxt[wb_preg] = 1'b1;
    if (alloc) rdy_nxt[new_p] = 1'b0;
  end

  // Mapping table, ready bits, free list and output stage
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NUM_AREG); i++) rat[i] <= PW'(i);
      for (int i = 0; i < int'(NUM_PREG); i++)
        fifo[i] <= (i < int'(FREE_INIT)) ? PW'(i + int'(NUM_AREG)) : '0;
      rdy          <= '1;
      head         <= '0;
      tail         <= PW'(FREE_INIT);
      free_count   <= CW'(FREE_INIT);
      out_valid    <= 1'b0;
      out_sr1_p    <= '0;
      out_sr2_p    <= '0;
      out_dr_p     <= '0;
      out_old_dr_p <= '0;
      out_s1_ready <= 1'b0;
      out_s2_ready <= 1'b0;
    end else begin
      if (alloc) begin
        rat[in_dr] <= new_p;
        head       <= head_nxt;
      end
      if (push) begin
        fifo[tail] <= cm_preg;
        tail       <= tail_nxt;
      end
      free_count <= free_count + CW'(push) - CW'(alloc);
      rdy        <= rdy_nxt;

      if (xfer) begin
        out_valid    <= 1'b1;
        out_sr1_p    <= s1_p;
        out_sr2_p    <= s2_p;
        out_dr_p     <= new_p;
        out_old_dr_p <= old_p;
        out_s1_ready <= s1_rdy;
        out_s2_ready <= s2_rdy;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rename_rat.sv
// Self-checking bench for rename_rat: directed vector table, corner sequences, random vs. model.
module tb_rename_rat;

  localparam int NA = 32;
  localparam int NP = 64;
  localparam int AW = 5;
  localparam int PW = 6;
`ifdef RENAME_WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, in_ready, in_we;
  logic [AW-1:0] in_sr1, in_sr2, in_dr;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_sr1_p, out_sr2_p, out_dr_p, out_old_dr_p;
  logic          out_s1_ready, out_s2_ready;
  logic          wb_valid, cm_valid;
  logic [PW-1:0] wb_preg, cm_preg;
  logic [PW:0]   free_count;

  always #5 clk = ~clk;

  rename_rat dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sr1_p(out_sr1_p), .out_sr2_p(out_sr2_p),
    .out_dr_p(out_dr_p), .out_old_dr_p(out_old_dr_p),
    .out_s1_ready(out_s1_ready), .out_s2_ready(out_s2_ready),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .cm_valid(cm_valid), .cm_preg(cm_preg),
    .free_count(free_count)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int v, input int s1, input int s2, input int d, input int we);
    in_valid = v[0];
    in_sr1   = AW'(s1);
    in_sr2   = AW'(s2);
    in_dr    = AW'(d);
    in_we    = we[0];
  endtask

  task automatic set_side(input int wv, input int wp, input int cv, input int cp);
    wb_valid = wv[0];
    wb_preg  = PW'(wp);
    cm_valid = cv[0];
    cm_preg  = PW'(cp);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    set_in(0, 0, 0, 0, 0);
    set_side(0, 0, 0, 0);
    out_ready = 1'b1;
    tick();
    rstn = 1'b1;
  endtask

  task automatic chk_out(input string tag, input int s1p, input int s1r, input int s2p,
                         input int s2r, input int drp, input int old, input int fc);
    chk({tag, ".valid"}, int'(out_valid), 1);
    chk({tag, ".sr1_p"}, int'(out_sr1_p), s1p);
    chk({tag, ".s1_rdy"}, int'(out_s1_ready), s1r);
    chk({tag, ".sr2_p"}, int'(out_sr2_p), s2p);
    chk({tag, ".s2_rdy"}, int'(out_s2_ready), s2r);
    chk({tag, ".dr_p"}, int'(out_dr_p), drp);
    chk({tag, ".old_dr_p"}, int'(out_old_dr_p), old);
    chk({tag, ".free_count"}, int'(free_count), fc);
  endtask

  typedef struct {
    int sr1, sr2, dr, we, wbv, wbp;
    int e_s1p, e_s1r, e_s2p, e_s2r, e_drp, e_old, e_fc;
  } vec_t;

  // Behavioural model state for the random phase
  int  m_rat [NA];
  bit  m_rdy [NP];
  int  free_q[$];
  int  pool[$];
  bit  m_ov;
  int  m_s1p, m_s1r, m_s2p, m_s2r, m_drp, m_old;

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_rat[i] = i;
    for (int i = 0; i < NP; i++) m_rdy[i] = 1'b1;
    free_q.delete();
    pool.delete();
    for (int i = NA; i < NP; i++) free_q.push_back(i);
    m_ov = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = '{5, 0, 5, 1, 0, 0,   5, 1,   0, 1, 32, 5, 31};
    tbl[1] = '{1, 2, 3, 1, 0, 0,   1, 1,   2, 1, 33, 3, 30};
    tbl[2] = '{3, 5, 0, 0, 0, 0,  33, 0,  32, 0,  0, 0, 30};
    tbl[3] = '{0, 4, 0, 1, 0, 0,   0, 1,   4, 1,  0, 0, 30};
    tbl[4] = '{5, 3, 5, 1, 0, 0,  32, 0,  33, 0, 34, 32, 29};
    tbl[5] = '{3, 0, 0, 0, 1, 33, 33, BYP, 0, 1,  0, 0, 29};
    tbl[6] = '{3, 5, 0, 0, 0, 0,  33, 1,  34, 0,  0, 0, 29};
    tbl[7] = '{0, 5, 0, 0, 1, 0,   0, 1,  34, 0,  0, 0, 29};

    // Reset state
    do_reset();
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.dr_p", int'(out_dr_p), 0);
    chk("rst.sr1_p", int'(out_sr1_p), 0);
    chk("rst.free_count", int'(free_count), 32);
    chk("rst.in_ready", int'(in_ready), 1);

    // Directed vector table, back-to-back with out_ready high
    for (int i = 0; i < 8; i++) begin
      set_in(1, tbl[i].sr1, tbl[i].sr2, tbl[i].dr, tbl[i].we);
      set_side(tbl[i].wbv, tbl[i].wbp, 0, 0);
      #1;
      chk($sformatf("vec%0d.in_ready", i), int'(in_ready), 1);
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].e_s1p, tbl[i].e_s1r, tbl[i].e_s2p,
              tbl[i].e_s2r, tbl[i].e_drp, tbl[i].e_old, tbl[i].e_fc);
    end
    set_in(0, 0, 0, 0, 0);
    set_side(0, 0, 0, 0);
    tick();
    chk("drain.out_valid", int'(out_valid), 0);

    // Back-pressure: output held, no RAT change, one output consumed on release
    out_ready = 1'b0;
    set_in(1, 6, 0, 6, 1);
    tick();
    chk_out("stall0", 6, 1, 0, 1, 35, 6, 28);
    set_in(1, 6, 0, 7, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", k + 1), int'(in_ready), 0);
      tick();
      chk_out($sformatf("stall%0d", k + 1), 6, 1, 0, 1, 35, 6, 28);
    end
    out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0);
    tick();
    chk("release.out_valid", int'(out_valid), 0);
    set_in(1, 6, 7, 0, 0);
    tick();
    chk_out("post_stall", 35, 0, 7, 1, 0, 0, 28);

    // Reset mid-stream discards the in-flight allocation
    set_in(1, 0, 0, 9, 1);
    rstn = 1'b0;
    tick();
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.dr_p", int'(out_dr_p), 0);
    chk("midrst.free_count", int'(free_count), 32);
    rstn = 1'b1;
    set_in(1, 5, 9, 9, 1);
    tick();
    chk_out("after_rst", 5, 1, 9, 1, 32, 9, 31);

    // Exhaust the free list, then recycle through commits
    do_reset();
    for (int k = 0; k < 32; k++) begin
      set_in(1, 0, 0, (k % 31) + 1, 1);
      tick();
    end
    chk("exh.last_dr_p", int'(out_dr_p), 63);
    chk("exh.free_count", int'(free_count), 0);
    set_in(1, 0, 0, 1, 1);
    #1;
    chk("exh.in_ready_we", int'(in_ready), 0);
    set_in(1, 0, 0, 1, 0);
    #1;
    chk("exh.in_ready_nowe", int'(in_ready), 1);
    tick();
    chk("exh.nowe_valid", int'(out_valid), 1);
    chk("exh.nowe_dr_p", int'(out_dr_p), 0);
    set_in(0, 0, 0, 0, 0);
    set_side(0, 0, 1, 7);
    tick();
    chk("cm7.free_count", int'(free_count), 1);
    set_side(0, 0, 0, 0);
    set_in(1, 0, 0, 2, 1);
    tick();
    chk("cm7.realloc", int'(out_dr_p), 7);
    chk("cm7.free_count", int'(free_count), 0);

    // Same-cycle commit and allocate at free_count==1
    set_in(0, 0, 0, 0, 0);
    set_side(0, 0, 1, 8);
    tick();
    chk("cm8.free_count", int'(free_count), 1);
    set_in(1, 0, 0, 3, 1);
    set_side(0, 0, 1, 9);
    tick();
    chk("cmalloc.dr_p", int'(out_dr_p), 8);
    chk("cmalloc.free_count", int'(free_count), 1);
    set_in(1, 0, 0, 4, 1);
    set_side(0, 0, 1, 0);
    tick();
    chk("cm9.realloc", int'(out_dr_p), 9);
    chk("cm0.ignored", int'(free_count), 0);
    // Commit at empty is not allocatable in the same cycle
    set_in(1, 0, 0, 5, 1);
    set_side(0, 0, 1, 10);
    #1;
    chk("cm_empty.in_ready", int'(in_ready), 0);
    tick();
    chk("cm_empty.free_count", int'(free_count), 1);
    chk("cm_empty.out_valid", int'(out_valid), 0);

    // Randomized traffic against the behavioural model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit exp_rdy, xfer, alloc;
      int p;
      set_in(int'($urandom_range(0, 9) < 8), int'($urandom_range(0, NA - 1)),
             int'($urandom_range(0, NA - 1)), int'($urandom_range(0, NA - 1)),
             int'($urandom_range(0, 9) < 7));
      out_ready = ($urandom_range(0, 3) != 0);
      set_side(int'($urandom_range(0, 9) < 3), int'($urandom_range(0, NP - 1)), 0, 0);
      if (pool.size() > 0 && $urandom_range(0, 9) < 4) begin
        cm_valid = 1'b1;
        cm_preg  = PW'(pool.pop_front());
      end else if ($urandom_range(0, 49) == 0) begin
        cm_valid = 1'b1;
        cm_preg  = '0;
      end
      exp_rdy = (!m_ov || out_ready) && !(in_we && in_dr != 0 && free_q.size() == 0);
      xfer    = in_valid && exp_rdy;
      alloc   = xfer && in_we && in_dr != 0;
      if (alloc && wb_valid && int'(wb_preg) == free_q[0]) wb_valid = 1'b0;
      #1;
      chk("rnd.in_ready", int'(in_ready), int'(exp_rdy));

      if (m_ov && out_ready && m_old != 0) pool.push_back(m_old);
      if (xfer) begin
        m_s1p = (in_sr1 == 0) ? 0 : m_rat[in_sr1];
        m_s2p = (in_sr2 == 0) ? 0 : m_rat[in_sr2];
        m_s1r = int'(m_rdy[m_s1p] || (BYP == 1 && wb_valid && int'(wb_preg) == m_s1p));
        m_s2r = int'(m_rdy[m_s2p] || (BYP == 1 && wb_valid && int'(wb_preg) == m_s2p));
        m_drp = 0;
        m_old = 0;
      end
      p = 0;
      if (alloc) begin
        p = free_q.pop_front();
        m_old = m_rat[in_dr];
        m_drp = p;
        m_rat[in_dr] = p;
      end
      if (wb_valid && wb_preg != 0) m_rdy[wb_preg] = 1'b1;
      if (alloc) m_rdy[p] = 1'b0;
      if (cm_valid && cm_preg != 0) begin
        chk("rnd.no_overflow", int'(free_q.size() < NP), 1);
        free_q.push_back(int'(cm_preg));
      end
      if (xfer) m_ov = 1'b1;
      else if (out_ready) m_ov = 1'b0;

      @(posedge clk);
      #1;
      chk("rnd.out_valid", int'(out_valid), int'(m_ov));
      chk("rnd.free_count", int'(free_count), free_q.size());
      if (m_ov) begin
        chk("rnd.sr1_p", int'(out_sr1_p), m_s1p);
        chk("rnd.s1_rdy", int'(out_s1_ready), m_s1r);
        chk("rnd.sr2_p", int'(out_sr2_p), m_s2p);
        chk("rnd.s2_rdy", int'(out_s2_ready), m_s2r);
        chk("rnd.dr_p", int'(out_dr_p), m_drp);
        chk("rnd.old_dr_p", int'(out_old_dr_p), m_old);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
